uart_tx_serializer: RTL and testbench

- Asynchronous serial transmitter, 8N1 framing, LSB first.
- Sits directly downstream of the word-to-byte TX buffer.
- Consumes tx_data/tx_data_valid from that buffer and returns uart_tx_busy/uart_tx_done, which the buffer uses to pace its byte stream.
- Drives the physical txd line.

---
 rtl/uart_tx_serializer_if.sv | 29 ++
 rtl/uart_tx_serializer.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
// Byte handshake between the word-to-byte TX buffer (master) and the UART
// serializer (slave).
//   tx_data        : byte to transmit                 (master -> slave)
//   tx_data_valid  : one-cycle strobe, taken when idle (master -> slave)
//   uart_tx_busy   : frame in progress                 (slave -> master)
//   uart_tx_done   : one-cycle end-of-frame pulse      (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       uart_tx_busy;
   logic       uart_tx_done;

   modport master (
      output tx_data,
      output tx_data_valid,
      input  uart_tx_busy,
      input  uart_tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_data_valid,
      output uart_tx_busy,
      output uart_tx_done
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 asynchronous serial transmitter, LSB first. Accepts one byte per
// tx_data_valid strobe while idle and shifts it out on txd, one bit every
// CLKS_PER_BIT clocks. All outputs are registered.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   tx_if  : slave side of uart_tx_serializer_if (tx_data, tx_data_valid,
//            uart_tx_busy, uart_tx_done)
//   txd    : serial line, idle high
//
// Build option:
//   UART_TX_PARITY_EN : when defined, a parity bit is inserted between the
//                       data bits and the stop bit (even parity, or odd when
//                       PARITY_ODD = 1), giving an 11-bit frame.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD_RATE    = 115_200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD   = 1'b0
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_tx_serializer_if.slave        tx_if,
   output logic                       txd
);

   // Guard keeps the counter at least one bit wide for degenerate settings.
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_reg,  state_next;
   logic [BW-1:0] baud_reg,   baud_next;
   logic [2:0]    bit_reg,    bit_next;
   logic [7:0]    shift_reg,  shift_next;
   logic          txd_reg,    txd_next;
   logic          busy_reg,   busy_next;
   logic          done_reg,   done_next;
   logic          baud_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         txd_reg   <= 1'b1;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign baud_last = (baud_reg == BAUD_LAST);

   // Next-state logic. txd/busy/done are computed one cycle ahead so that the
   // registered outputs line up exactly with the state they describe.
   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      txd_next   = txd_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;

      // Every non-idle state uses the same baud tick.
      if (state_reg != IDLE) begin
         baud_next = baud_last ? '0 : baud_reg + BW'(1);
      end

      case (state_reg)
         IDLE: begin
            txd_next  = 1'b1;
            busy_next = 1'b0;
            if (tx_if.tx_data_valid) begin
               shift_next = tx_if.tx_data;
               state_next = START;
               busy_next  = 1'b1;
               txd_next   = 1'b0;
               baud_next  = '0;
            end
         end
         START: begin
            if (baud_last) begin
               state_next = DATA;
               bit_next   = 3'd0;
               txd_next   = shift_reg[0];
            end
         end
         DATA: begin
            if (baud_last) begin
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
                  txd_next   = (^shift_reg) ^ PARITY_ODD;
`else
                  state_next = STOP;
                  txd_next   = 1'b1;
`endif
                  bit_next   = 3'd0;
               end else begin
                  bit_next = bit_reg + 3'd1;
                  txd_next = shift_reg[bit_reg + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               state_next = STOP;
               txd_next   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               // done is visible on the first idle cycle, the same edge busy drops.
               state_next = IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               txd_next   = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign txd                = txd_reg;
   assign tx_if.uart_tx_busy = busy_reg;
   assign tx_if.uart_tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Bench for uart_tx_serializer at CLKS_PER_BIT = 10. A frame-level model
// (frame bit vector + elapsed-cycle count) predicts txd/busy/done every cycle;
// directed scenarios add literal expectations on line bits and pulse counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_serializer;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam bit PODD  = 1'b0;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic txd;

   uart_tx_serializer_if bus();

   uart_tx_serializer #(
      .CLK_FREQ  (50_000_000),
      .BAUD_RATE (5_000_000)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tx_if (bus.slave),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame as a bit vector in line order: index 0 = start bit.
   function automatic logic [10:0] build_frame(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = (^b) ^ PODD;
`endif
      return f;
   endfunction

   // ---------------- model + per-cycle compare ----------------
   int          elapsed     = -1;   // cycles since frame start, -1 when idle
   logic [10:0] frame_bits  = '1;
   bit          done_exp    = 1'b0;
   int          busy_cycles = 0;
   int          done_count  = 0;
   logic        line_log [0:16383];
   int          line_n      = 0;

   initial begin
      logic exp_txd, exp_busy, exp_done;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_txd = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
         end else if (elapsed >= 0) begin
            exp_txd = frame_bits[elapsed / CPB]; exp_busy = 1'b1; exp_done = 1'b0;
         end else begin
            exp_txd = 1'b1; exp_busy = 1'b0; exp_done = done_exp;
         end
         check("txd",  {31'd0, txd},                exp_txd);
         check("busy", {31'd0, bus.uart_tx_busy},   exp_busy);
         check("done", {31'd0, bus.uart_tx_done},   exp_done);

         if (bus.uart_tx_busy === 1'b1) begin
            busy_cycles++;
            if (line_n < 16384) begin
               line_log[line_n] = txd;
               line_n++;
            end
         end
         if (bus.uart_tx_done === 1'b1) done_count++;

         // Advance to the state after the coming rising edge.
         if (rst) begin
            elapsed  = -1;
            done_exp = 1'b0;
         end else if (elapsed >= 0) begin
            elapsed++;
            if (elapsed == FRAME_CYC) begin
               elapsed  = -1;
               done_exp = 1'b1;
            end
         end else begin
            done_exp = 1'b0;
            if (bus.tx_data_valid) begin
               elapsed    = 0;
               frame_bits = build_frame(bus.tx_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.tx_data       = b;
      bus.tx_data_valid = 1'b1;
      $display("send byte 0x%02h at %0t", b, $time);
      step();
      bus.tx_data_valid = 1'b0;
   endtask

   initial begin
      int d0, b0, s, k;
      logic [9:0] a5_line;
      bit seen;

      bus.tx_data       = 8'h00;
      bus.tx_data_valid = 1'b0;
      #1 rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (20) step();

      // Single byte 0xA5
      d0 = done_count; b0 = busy_cycles; s = line_n;
      send(8'hA5);
      repeat (FRAME_CYC + 5) step();
      check("a5_done_pulses", done_count - d0, 1);
      check("a5_busy_cycles", busy_cycles - b0, FRAME_CYC);
      a5_line = 10'b1101001010;   // line order, bit 0 first: 0,1,0,1,0,0,1,0,1,1
      for (k = 0; k < 9; k++)
         check($sformatf("a5_bit%0d", k), {31'd0, line_log[s + k*CPB + CPB/2]}, {31'd0, a5_line[k]});
      check("a5_stop", {31'd0, line_log[s + (NBITS-1)*CPB + CPB/2]}, 1);

`ifdef UART_TX_PARITY_EN
      s = line_n;
      send(8'h07);
      repeat (FRAME_CYC + 5) step();
      check("par07_bit", {31'd0, line_log[s + 9*CPB + CPB/2]}, 1);
`endif

      // Ignore while busy: second strobe with new data at cycle 40
      d0 = done_count; b0 = busy_cycles;
      send(8'h3C);
      repeat (39) step();
      bus.tx_data = 8'hFF; bus.tx_data_valid = 1'b1;
      step();
      bus.tx_data_valid = 1'b0;
      repeat (FRAME_CYC + 5) step();
      check("ignore_done_pulses", done_count - d0, 1);
      check("ignore_busy_cycles", busy_cycles - b0, FRAME_CYC);

      // Back-to-back: strobe on the done cycle
      d0 = done_count; b0 = busy_cycles;
      send(8'h00);
      seen = 1'b0;
      for (int i = 0; i < FRAME_CYC + 20 && !seen; i++) begin
         if (bus.uart_tx_done === 1'b1) seen = 1'b1;
         else step();
      end
      check("b2b_done_seen", {31'd0, seen}, 1);
      bus.tx_data = 8'h81; bus.tx_data_valid = 1'b1;
      $display("send byte 0x81 at %0t (done cycle)", $time);
      step();
      bus.tx_data_valid = 1'b0;
      check("b2b_second_start_txd", {31'd0, txd}, 0);
      repeat (FRAME_CYC + 5) step();
      check("b2b_done_pulses", done_count - d0, 2);
      check("b2b_busy_cycles", busy_cycles - b0, 2 * FRAME_CYC);

      // Mid-frame reset
      d0 = done_count;
      send(8'h55);
      repeat (34) step();
      rst = 1'b1;
      #2;
      check("rst_txd_immediate",  {31'd0, txd}, 1);
      check("rst_busy_immediate", {31'd0, bus.uart_tx_busy}, 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (FRAME_CYC) step();
      check("rst_no_done", done_count - d0, 0);
      d0 = done_count;
      send(8'h0F);
      repeat (FRAME_CYC + 5) step();
      check("post_rst_done_pulses", done_count - d0, 1);

      // Random strobes with data churning every cycle
      for (int i = 0; i < 800; i++) begin
         bus.tx_data       = 8'($urandom);
         bus.tx_data_valid = ($urandom_range(0, 24) == 0);
         if (bus.tx_data_valid) $display("strobe byte 0x%02h at %0t", bus.tx_data, $time);
         step();
      end
      bus.tx_data_valid = 1'b0;
      repeat (FRAME_CYC + 5) step();

      // Valid held high: one frame per idle cycle
      d0 = done_count;
      bus.tx_data_valid = 1'b1;
      for (int i = 0; i < 3 * (FRAME_CYC + 1); i++) begin
         bus.tx_data = 8'($urandom);
         step();
      end
      bus.tx_data_valid = 1'b0;
      repeat (5) step();
      check("held_valid_done_pulses", done_count - d0, 3);

      repeat (5) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
